// File: rtl/btn_click_classifier.sv
// btn_click_classifier: groups debounced press pulses into single/double/triple
// click events. A group stays open while successive presses arrive within
// WINDOW_MS ms ticks of each other (one tick = F_COUNT clk cycles).
module btn_click_classifier #(
  parameter int unsigned F_COUNT   = 100_000,
  parameter int unsigned WINDOW_MS = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic i_press,
  output logic o_single,
  output logic o_double,
  output logic o_triple,
  output logic o_busy
);

  localparam int unsigned PW = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
  localparam int unsigned MW = $clog2(WINDOW_MS + 1);

  localparam logic [PW-1:0] P_LAST  = PW'(F_COUNT - 1);
  localparam logic [MW-1:0] MS_LAST = MW'(WINDOW_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_TWO  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [MW-1:0] r_ms;
  logic [MW-1:0] w_ms_nxt;
  logic          w_single_nxt;
  logic          w_double_nxt;
  logic          w_triple_nxt;
  logic          w_timeout;
  logic          w_tick_presc_last;

  // Window expiry: last prescaler step of the last ms tick, and no press to rescue the group
  assign w_tick_presc_last = (r_presc == P_LAST);
  assign w_timeout         = w_tick_presc_last && (r_ms == MS_LAST) && !i_press;

  // A group is open whenever the FSM is away from IDLE
  assign o_busy = (r_state != S_IDLE);

  // Next-state, counter and event decode
  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_ms_nxt     = r_ms;
    w_single_nxt = 1'b0;
    w_double_nxt = 1'b0;
    w_triple_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_presc_nxt = '0;
        w_ms_nxt    = '0;
        if (i_press) begin
          w_state_nxt = S_ONE;
        end
      end

      S_ONE: begin
        if (i_press) begin
          w_state_nxt = S_TWO;
          w_presc_nxt = '0;
          w_ms_nxt    = '0;
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_single_nxt = 1'b1;
          w_presc_nxt  = '0;
          w_ms_nxt     = '0;
        end else if (w_tick_presc_last) begin
          w_presc_nxt = '0;
          w_ms_nxt    = r_ms + MW'(1);
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end

      S_TWO: begin
        if (i_press) begin
          w_state_nxt  = S_IDLE;
          w_triple_nxt = 1'b1;
          w_presc_nxt  = '0;
          w_ms_nxt     = '0;
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_double_nxt = 1'b1;
          w_presc_nxt  = '0;
          w_ms_nxt     = '0;
        end else if (w_tick_presc_last) begin
          w_presc_nxt = '0;
          w_ms_nxt    = r_ms + MW'(1);
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_presc_nxt = '0;
        w_ms_nxt    = '0;
      end
    endcase
  end

  // State, counters and registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_ms     <= '0;
      o_single <= 1'b0;
      o_double <= 1'b0;
      o_triple <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_ms     <= w_ms_nxt;
      o_single <= w_single_nxt;
      o_double <= w_double_nxt;
      o_triple <= w_triple_nxt;
    end
  end

endmodule

// File: tb/tb_btn_click_classifier.sv
// Bench for btn_click_classifier: press-count/age reference model checked every
// cycle, directed scenarios with literal event times, then random presses.
module tb_btn_click_classifier;

  localparam int unsigned F_COUNT   = 4;
  localparam int unsigned WINDOW_MS = 3;
  localparam int          WIN       = F_COUNT * WINDOW_MS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_press = 1'b0;
  logic o_single, o_double, o_triple, o_busy;

  int checks = 0;
  int errors = 0;

  btn_click_classifier #(
    .F_COUNT  (F_COUNT),
    .WINDOW_MS(WINDOW_MS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_press (i_press),
    .o_single(o_single),
    .o_double(o_double),
    .o_triple(o_triple),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  // Reference model: number of presses in the open group and cycles since the last one
  int   m_cnt = 0;
  int   m_age = 0;
  logic exp_s = 1'b0, exp_d = 1'b0, exp_t = 1'b0;
  logic m_valid = 1'b0;

  always @(posedge clk) begin
    exp_s = 1'b0;
    exp_d = 1'b0;
    exp_t = 1'b0;
    if (rst) begin
      m_cnt   = 0;
      m_age   = 0;
      m_valid = 1'b1;
    end else if (m_cnt == 0) begin
      if (i_press) begin
        m_cnt = 1;
        m_age = 0;
      end
    end else if (i_press) begin
      if (m_cnt == 2) begin
        exp_t = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = 2;
        m_age = 0;
      end
    end else begin
      m_age++;
      if (m_age == WIN) begin
        if (m_cnt == 1) exp_s = 1'b1;
        else            exp_d = 1'b1;
        m_cnt = 0;
        m_age = 0;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model, mid-cycle
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ({o_single, o_double, o_triple, o_busy} !== {exp_s, exp_d, exp_t, (m_cnt != 0)}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got s/d/t/busy=%b%b%b%b want %b%b%b%b", $time,
                 o_single, o_double, o_triple, o_busy, exp_s, exp_d, exp_t, (m_cnt != 0));
      end
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    i_press = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive presses on relative edges given by pmask (rst on edge rst_at), log first event edges
  task automatic directed(input logic [63:0] pmask, input int rst_at, input int ncyc,
                          output int s_at, output int d_at, output int t_at,
                          output int ns, output int nd, output int nt);
    s_at = -1; d_at = -1; t_at = -1;
    ns = 0; nd = 0; nt = 0;
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (o_single) begin ns++; if (s_at < 0) s_at = k - 1; end
        if (o_double) begin nd++; if (d_at < 0) d_at = k - 1; end
        if (o_triple) begin nt++; if (t_at < 0) t_at = k - 1; end
      end
      if (k < ncyc) begin
        i_press = pmask[k];
        rst     = (k == rst_at);
      end else begin
        i_press = 1'b0;
        rst     = 1'b0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int s_at, d_at, t_at, ns, nd, nt;
    logic [63:0] m;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_single, o_double, o_triple, o_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {o_single, o_double, o_triple, o_busy});
    end
    rst = 1'b0;

    // 1: single press
    reset_pulse();
    m = '0; m[0] = 1'b1;
    directed(m, -1, 30, s_at, d_at, t_at, ns, nd, nt);
    check_int("t1_single_edge", s_at, 12);
    check_int("t1_single_cnt", ns, 1);
    check_int("t1_other_cnt", nd + nt, 0);

    // 2: presses at 0 and 5
    reset_pulse();
    m = '0; m[0] = 1'b1; m[5] = 1'b1;
    directed(m, -1, 30, s_at, d_at, t_at, ns, nd, nt);
    check_int("t2_double_edge", d_at, 17);
    check_int("t2_double_cnt", nd, 1);
    check_int("t2_other_cnt", ns + nt, 0);

    // 3: presses at 0, 4, 8
    reset_pulse();
    m = '0; m[0] = 1'b1; m[4] = 1'b1; m[8] = 1'b1;
    directed(m, -1, 30, s_at, d_at, t_at, ns, nd, nt);
    check_int("t3_triple_edge", t_at, 8);
    check_int("t3_triple_cnt", nt, 1);
    check_int("t3_other_cnt", ns + nd, 0);

    // 4: second press on the timeout cycle
    reset_pulse();
    m = '0; m[0] = 1'b1; m[12] = 1'b1;
    directed(m, -1, 36, s_at, d_at, t_at, ns, nd, nt);
    check_int("t4_double_edge", d_at, 24);
    check_int("t4_single_cnt", ns, 0);

    // 5: reset mid-group, then a fresh press
    reset_pulse();
    m = '0; m[0] = 1'b1; m[10] = 1'b1;
    directed(m, 6, 36, s_at, d_at, t_at, ns, nd, nt);
    check_int("t5_single_edge", s_at, 22);
    check_int("t5_single_cnt", ns, 1);
    check_int("t5_other_cnt", nd + nt, 0);

    // 6: four presses, triple then new group
    reset_pulse();
    m = '0; m[0] = 1'b1; m[2] = 1'b1; m[4] = 1'b1; m[6] = 1'b1;
    directed(m, -1, 30, s_at, d_at, t_at, ns, nd, nt);
    check_int("t6_triple_edge", t_at, 4);
    check_int("t6_single_edge", s_at, 18);
    check_int("t6_double_cnt", nd, 0);

    // Random presses with varied gaps, occasional reset and held-high press
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 3))
        0:       i_press = ($urandom_range(0, 2) == 0);
        1:       i_press = ($urandom_range(0, 9) == 0);
        default: i_press = ($urandom_range(0, 14) == 0);
      endcase
    end
    @(negedge clk);
    i_press = 1'b0;
    rst = 1'b0;
    repeat (WIN + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
